// File: rtl/alu_rr_sched_pkg.sv
// rtl/alu_rr_sched_pkg.sv - shared ALU op codes, scheduler states and reject rule
package alu_sched_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_MUL    = 4'b0010;
  localparam logic [3:0] ALU_DIV    = 4'b0011;
  localparam logic [3:0] ALU_OP_MAX = 4'b0011;

  // Value the stand-in ALU presents out of reset or for unknown selects.
  localparam logic [7:0] ALU_DEFAULT_OUT = 8'hAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Operations the ALU must never see: unknown selects and divide-by-zero.
  function automatic logic op_rejected(input logic [3:0] op, input logic [7:0] b);
    return (op > ALU_OP_MAX) || ((op == ALU_DIV) && (b == 8'h00));
  endfunction

endpackage

// File: rtl/alu_rr_sched_if.sv
// rtl/alu_rr_sched_if.sv - request/response bundle between requesters and the scheduler
interface alu_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_op;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_result;
  logic                 rsp_carry;
  logic                 rsp_err;

  // Requester / response-consumer side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err
  );

endinterface

// File: rtl/alu_rr_sched_arb.sv
// rtl/alu_rr_sched_arb.sv - combinational round-robin arbiter searching from ptr+1
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int              cand;
  logic [ID_W-1:0] cand_idx;
  logic            found;

  // Walk the ring starting just after the last winner; first active request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(ptr) + off) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin scheduler sharing one registered ALU among requesters
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic          clock,
  input  logic          reset,
  alu_rr_sched_if.slave bus,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_sel,
  input  logic [7:0]    alu_out,
  input  logic          alu_carry,
  output logic          busy
);

  // Counter holds ALU_LATENCY-1 at most.
  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [CNT_W-1:0]   lat_cnt;
  logic               take;

  logic [7:0]         a_arr  [NUM_REQ];
  logic [7:0]         b_arr  [NUM_REQ];
  logic [3:0]         op_arr [NUM_REQ];
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  logic [3:0]         sel_op;
  logic               sel_reject;

  logic [ID_W-1:0]    rsp_id_q;
  logic [7:0]         rsp_result_q;
  logic               rsp_carry_q;
  logic               rsp_err_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = bus.req_a[8*i +: 8];
    assign b_arr[i]  = bus.req_b[8*i +: 8];
    assign op_arr[i] = bus.req_op[4*i +: 4];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (gnt_onehot),
    .grant_idx (gnt_idx)
  );

  // Route the winning requester's operands and classify the operation.
  always_comb begin
    sel_a      = a_arr[gnt_idx];
    sel_b      = b_arr[gnt_idx];
    sel_op     = op_arr[gnt_idx];
    sel_reject = op_rejected(sel_op, sel_b);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus handshake outputs; a grant only happens from IDLE and never under reset.
  always_comb begin
    state_nxt     = state;
    take          = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        take          = (|gnt_onehot) && !reset;
        bus.req_ready = take ? gnt_onehot : '0;
        if (|gnt_onehot) begin
          state_nxt = sel_reject ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt == '0) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = !reset;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the accepted operation, count ALU latency, capture the ALU result.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      lat_cnt      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (take) begin
        rr_ptr   <= gnt_idx;
        rsp_id_q <= gnt_idx;
        if (sel_reject) begin
          rsp_result_q <= '0;
          rsp_carry_q  <= 1'b0;
          rsp_err_q    <= 1'b1;
        end else begin
          alu_a   <= sel_a;
          alu_b   <= sel_b;
          alu_sel <= sel_op;
          lat_cnt <= CNT_W'(ALU_LATENCY - 1);
        end
      end
      if ((state == EXEC) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (state == CAPT) begin
        rsp_result_q <= alu_out;
        rsp_carry_q  <= alu_carry;
        rsp_err_q    <= 1'b0;
      end
    end
  end

  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - self-checking bench for alu_rr_sched with a stand-in ALU
module tb_alu_rr_sched;
  import alu_sched_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       busy;
  logic [15:0] prod;

  alu_rr_sched_if #(.NUM_REQ(N)) bus ();

  alu_rr_sched #(
    .NUM_REQ     (N),
    .ALU_LATENCY (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  assign prod = {8'h00, alu_a} * {8'h00, alu_b};

  // Stand-in registered ALU sharing the scheduler's reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_out   <= ALU_DEFAULT_OUT;
      alu_carry <= 1'b0;
    end else begin
      case (alu_sel)
        ALU_ADD: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        ALU_SUB: {alu_carry, alu_out} <= {1'b0, alu_a} - {1'b0, alu_b};
        ALU_MUL: begin
          alu_out   <= prod[7:0];
          alu_carry <= |prod[15:8];
        end
        ALU_DIV: begin
          alu_out   <= alu_a / alu_b;
          alu_carry <= 1'b0;
        end
        default: begin
          alu_out   <= ALU_DEFAULT_OUT;
          alu_carry <= 1'b0;
        end
      endcase
    end
  end

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] va [N];
  logic [7:0] vb [N];
  logic [3:0] vo [N];
  logic       vv [N];
  int         m_ptr;
  int         g;
  int         w;
  int         n;
  int         guard;
  int         hold;
  int         mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU semantics from plain integer arithmetic.
  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int r, output int c, output int e);
    r = 0;
    c = 0;
    e = 0;
    if (op > 3 || (op == 3 && b == 0)) begin
      e = 1;
    end else begin
      case (op)
        0: begin r = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
        1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;       end
        2: begin r = (a * b) % 256;       c = (a * b > 255) ? 1 : 0; end
        default: begin r = a / b;         c = 0;                     end
      endcase
    end
  endfunction

  // Round-robin expectation: first active requester after the last one served.
  function automatic int ref_grant(input int ptr);
    int cnd;
    for (int off = 1; off <= N; off++) begin
      cnd = (ptr + off) % N;
      if (vv[cnd]) return cnd;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]      = vv[i];
      bus.req_a[8*i +: 8]   = va[i];
      bus.req_b[8*i +: 8]   = vb[i];
      bus.req_op[4*i +: 4]  = vo[i];
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    va[i] = a;
    vb[i] = b;
    vo[i] = op;
    vv[i] = 1'b1;
  endtask

  // One full transaction: grant, latency, ALU drive, response contents, optional backpressure.
  task automatic expect_txn(input string tag, input int hold_cyc, output int gnt, output int waited);
    int eg, er, ec, ee, lat, k;
    logic [7:0] a0, b0;
    logic [3:0] s0;
    logic [3:0] rr;
    gnt    = -1;
    waited = 0;
    bus.rsp_ready = (hold_cyc == 0);
    eg = ref_grant(m_ptr);
    while (bus.req_ready == '0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check({tag, "_grant_seen"}, (waited < 20), 1);
    if (waited >= 20) return;
    rr = bus.req_ready;
    for (int i = N - 1; i >= 0; i--) if (rr[i]) gnt = i;
    check({tag, "_onehot"}, $onehot(rr), 1);
    check({tag, "_grant"}, gnt, eg);
    if (eg < 0) return;
    ref_alu(int'(va[eg]), int'(vb[eg]), int'(vo[eg]), er, ec, ee);
    a0 = alu_a;
    b0 = alu_b;
    s0 = alu_sel;
    m_ptr = eg;
    @(posedge clock);
    #1;
    vv[eg] = 1'b0;
    drive();
    lat = (ee != 0) ? 1 : LAT + 2;
    k = 0;
    while (k < 20) begin
      @(negedge clock);
      k++;
      if (k == 1 && ee == 0)
        check({tag, "_alu_in"}, {alu_a, alu_b, alu_sel}, {va[eg], vb[eg], vo[eg]});
      if (bus.rsp_valid) break;
      check({tag, "_busy"}, busy, 1);
    end
    check({tag, "_latency"}, k, lat);
    if (ee != 0) check({tag, "_alu_held"}, {alu_a, alu_b, alu_sel}, {a0, b0, s0});
    check({tag, "_rsp"}, {bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_err},
          {eg[1:0], er[7:0], ec[0], ee[0]});
    for (int h = 1; h < hold_cyc; h++) begin
      @(negedge clock);
      check({tag, "_stall"},
            {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_err, bus.req_ready},
            {1'b1, eg[1:0], er[7:0], ec[0], ee[0], 4'b0000});
    end
    bus.rsp_ready = 1'b1;
    #1;
    @(negedge clock);
    check({tag, "_done"}, {bus.rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = '0; vb[i] = '0; vo[i] = '0; vv[i] = 1'b0;
    end
    set_req(0, 8'h11, 8'h22, ALU_ADD);
    drive();
    repeat (3) @(negedge clock);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_err}, 0);
    check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    vv[0] = 1'b0;
    drive();
    reset = 1'b0;
    m_ptr = N - 1;
    @(negedge clock);

    set_req(0, 8'h9d, 8'h60, ALU_ADD);
    drive();
    expect_txn("add0", 0, g, w);
    check("add0_who", g, 0);

    set_req(2, 8'hb1, 8'h9f, ALU_ADD);
    drive();
    expect_txn("add2", 0, g, w);
    check("add2_who", g, 2);

    set_req(3, 8'($urandom), 8'($urandom), ALU_SUB);
    drive();
    expect_txn("sub3", 0, g, w);

    set_req(0, 8'h0e, 8'h0b, ALU_MUL);
    set_req(1, 8'hf4, 8'h2f, ALU_DIV);
    set_req(3, 8'h55, 8'h36, ALU_SUB);
    drive();
    expect_txn("held_a", 0, g, w);
    check("held_order0", g, 0);
    expect_txn("held_b", 0, g, w);
    check("held_order1", g, 1);
    expect_txn("held_c", 0, g, w);
    check("held_order3", g, 3);

    set_req(1, 8'($urandom), 8'h00, ALU_DIV);
    drive();
    expect_txn("div0", 0, g, w);
    set_req(1, 8'($urandom), 8'($urandom), 4'b0100);
    drive();
    expect_txn("badop", 0, g, w);

    set_req(2, 8'h40, 8'h05, ALU_MUL);
    drive();
    expect_txn("pre_bp", 0, g, w);
    set_req(3, 8'h7f, 8'h01, ALU_ADD);
    set_req(2, 8'h03, 8'h09, ALU_SUB);
    drive();
    expect_txn("bp3", 5, g, w);
    check("bp_next_ready", bus.req_ready, 4'b0100);
    expect_txn("bp2", 0, g, w);
    check("bp2_who", g, 2);
    check("bp2_wait", w, 0);

    set_req(1, 8'h12, 8'h34, ALU_SUB);
    drive();
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("rst_mid_grant", bus.req_ready, 4'b0010);
    @(posedge clock);
    #1;
    vv[1] = 1'b0;
    set_req(2, 8'h01, 8'h02, ALU_ADD);
    drive();
    @(negedge clock);
    check("rst_mid_exec", {busy, alu_sel}, {1'b1, ALU_SUB});
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_after", {busy, bus.rsp_valid, alu_sel, bus.req_ready}, 0);
    vv[2] = 1'b0;
    drive();
    reset = 1'b0;
    m_ptr = N - 1;
    set_req(3, 8'h20, 8'h10, ALU_ADD);
    set_req(0, 8'h08, 8'h04, ALU_DIV);
    drive();
    expect_txn("post_rst_a", 0, g, w);
    check("post_rst_first", g, 0);
    expect_txn("post_rst_b", 0, g, w);

    for (int round = 0; round < 25; round++) begin
      mask = $urandom_range(1, 15);
      for (int i = 0; i < N; i++) begin
        if (mask[i])
          set_req(i, 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                  4'($urandom_range(0, 5)));
      end
      drive();
      guard = 0;
      while ((vv[0] || vv[1] || vv[2] || vv[3]) && guard < 8) begin
        hold = $urandom_range(0, 3);
        expect_txn("rand", hold, g, w);
        guard++;
      end
      check("rand_drained", guard <= N, 1);
      for (int i = 0; i < N; i++) vv[i] = 1'b0;
      drive();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one registered 8-bit ALU (ops ADD/SUB/MUL/DIV, 1-cycle registered output, CarryOut flag) between NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand/select inputs.
- Waits ALU_LATENCY cycles, captures ALU_Out/CarryOut, and returns the result with the requester ID.
- Rejects divide-by-zero and unsupported selects without issuing them to the ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LATENCY, 1, cycles from ALU input change to valid ALU_Out (>=1).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*8  packed operand A, requester i at [8i+7:8i].
- req_b  in  NUM_REQ*8  packed operand B.
- req_op  in  NUM_REQ*4  packed ALU select.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_result  out  8  captured ALU_Out, or 0 on error.
- rsp_carry  out  1  captured CarryOut, or 0 on error.
- rsp_err  out  1  1 = rejected (div-by-zero or op>3).
- alu_a  out  8  to ALU A, registered.
- alu_b  out  8  to ALU B, registered.
- alu_sel  out  4  to ALU_Sel, registered.
- alu_out  in  8  from ALU_Out.
- alu_carry  in  1  from CarryOut.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, active-high):
  - State = IDLE; rr pointer = NUM_REQ-1, so requester 0 has priority first.
  - All outputs 0: alu_a, alu_b, alu_sel, rsp_*, req_ready, busy.
  - Reset mid-operation aborts the in-flight operation: no response and no req_ready in that cycle.
  - The ALU shares the same reset.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - If any req_valid, grant the first valid requester searching from pointer+1 modulo NUM_REQ.
  - req_ready[grant] is combinational, high that cycle only; the transfer happens on that edge.
  - On transfer, latch a, b, op and ID. Pointer = grant.
  - If op==3 and b==0, or op>3: go to RESP with err=1, result=0, carry=0. ALU inputs are not updated.
  - Otherwise load alu_a, alu_b, alu_sel and go to EXEC.
  - req_ready is 0 in every state except IDLE.
- EXEC:
  - Hold ALU inputs stable.
  - A down-counter loaded with ALU_LATENCY-1 expires after ALU_LATENCY cycles; then go to CAPT.
- CAPT:
  - ALU inputs still held.
  - At the edge, rsp_result<=alu_out, rsp_carry<=alu_carry, rsp_err<=0; go to RESP.
- RESP:
  - rsp_valid=1, and rsp_id/result/carry/err are stable until the handshake.
  - On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid at that edge.
  - No new grant is made in the same cycle as the response handshake.
- Latency:
  - Accept at cycle T; rsp_valid first high at T+ALU_LATENCY+2 (T+3 by default).
  - Error responses: rsp_valid at T+1.
- ALU inputs keep their last values while IDLE; they are not cleared.
- A requester dropping req_valid while waiting is legal. Arbitration uses only the current cycle's valids.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.
- Throughput: at most one operation in flight.

Decomposition:
- alu_sched_pkg holds:
  - op constants ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_MUL=4'b0010, ALU_DIV=4'b0011, ALU_OP_MAX=4'b0011;
  - state enum (IDLE, EXEC, CAPT, RESP);
  - ALU_DEFAULT_OUT=8'hAC, used by benches only.
- One sub-module, rr_arbiter:
  - inputs: req vector, pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- Top level holds the FSM, latency counter and registers. The ALU is instantiated alongside the scheduler at the next level up, not inside it.

Test Plan:
- Requester 0: A=8'h9d, B=8'h60, op ADD, rsp_ready=1 → req_ready[0] in accept cycle T; alu_sel=0 during EXEC; rsp_valid at T+3 with rsp_id=0, result=8'hfd, carry=0, err=0.
- Requester 2: A=8'hb1, B=8'h9f, ADD → result=8'h50, carry=1, rsp_id=2.
- Requesters 0, 1 and 3 valid simultaneously and held (0: MUL 8'h0e×8'h0b; 1: DIV 8'hf4/8'h2f; 3: SUB 8'h55-8'h36):
  - grant order is 0, 1, 3;
  - results are 8'h9a, 8'h05, 8'h1f;
  - req_ready is never high in two bits at once.
- Requester 1: DIV with B=0, then op=4'b0100 →
  - each gives rsp_err=1, result=0, rsp_valid at T+1;
  - alu_a, alu_b and alu_sel stay unchanged.
- rsp_ready held low 5 cycles in RESP while requester 2 is valid →
  - rsp_* stable for all 5 cycles;
  - req_ready stays 0;
  - requester 2 is granted only in the cycle after the handshake.
- reset asserted in EXEC →
  - next cycle: state IDLE, rsp_valid=0, busy=0, alu_sel=0;
  - after release, requester 0 is granted first.
